// File: rtl/cmult_sched.sv
// Round-robin scheduler sharing one pipelined complex multiplier among NUM_REQ
// requesters, with credit-gated issue and an in-order first-word-fall-through response FIFO.
module cmult_sched #(
  parameter int NUM_REQ    = 4,
  parameter int MULT_LAT   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*32-1:0]      i_req_mcand,
  input  logic [NUM_REQ*32-1:0]      i_req_mplier,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic [31:0]                o_mult_mcand,
  output logic [31:0]                o_mult_mplier,
  input  logic [31:0]                i_mult_result,
  output logic                       o_rsp_valid,
  output logic [31:0]                o_rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] o_rsp_id,
  input  logic                       i_rsp_ready,
  output logic                       o_busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C  = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [MULT_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [IDW-1:0]      tag_id_q [MULT_LAT];
  logic [IDW-1:0]      tag_id_d [MULT_LAT];
  logic [CW-1:0]       inflight_q, inflight_d;
  logic [CW-1:0]       fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [31:0]         fifo_data_q [FIFO_DEPTH];
  logic [31:0]         fifo_data_d [FIFO_DEPTH];
  logic [IDW-1:0]      fifo_id_q [FIFO_DEPTH];
  logic [IDW-1:0]      fifo_id_d [FIFO_DEPTH];

  logic           credit_ok, gnt_found, transfer, push, pop;
  logic [IDW-1:0] gnt_id;
  int unsigned    idx;

  // Credit uses registered occupancy only, so a pop this cycle frees a slot next cycle.
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < DEPTH_C;

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!gnt_found && i_req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
  end

  // Reset gates the combinational accept so nothing is granted while i_rst is high.
  assign transfer = gnt_found && credit_ok && !i_rst;
  assign push     = tag_vld_q[MULT_LAT-1];
  assign pop      = o_rsp_valid && i_rsp_ready;

  always_comb begin
    o_req_ready   = '0;
    o_mult_mcand  = '0;
    o_mult_mplier = '0;
    if (transfer) begin
      o_req_ready   = NUM_REQ'(1) << gnt_id;
      o_mult_mcand  = i_req_mcand[32*gnt_id +: 32];
      o_mult_mplier = i_req_mplier[32*gnt_id +: 32];
    end
  end

  always_comb begin
    rr_ptr_d    = transfer ? IDW'((32'(gnt_id) + 1) % NUM_REQ) : rr_ptr_q;
    tag_vld_d   = '0;
    tag_id_d    = tag_id_q;
    tag_vld_d[0] = transfer;
    tag_id_d[0]  = gnt_id;
    for (int unsigned i = 1; i < MULT_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end

    inflight_d = inflight_q;
    case ({transfer, push})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    fifo_data_d = fifo_data_q;
    fifo_id_d   = fifo_id_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = i_mult_result;
      fifo_id_d[wr_ptr_q]   = tag_id_q[MULT_LAT-1];
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr_q   <= '0;
      tag_vld_q  <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int unsigned i = 0; i < MULT_LAT; i++) tag_id_q[i] <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_id_q[i]   <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      inflight_q  <= inflight_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_data_q <= fifo_data_d;
      fifo_id_q   <= fifo_id_d;
    end
  end

  assign o_rsp_valid = (fifo_cnt_q != '0);
  assign o_rsp_data  = fifo_data_q[rd_ptr_q];
  assign o_rsp_id    = fifo_id_q[rd_ptr_q];
  assign o_busy      = (inflight_q != '0) || (fifo_cnt_q != '0);

endmodule

// File: tb/tb_cmult_sched.sv
// Bench for cmult_sched: queue-based transaction model plus a behavioural FP16
// complex multiplier, with directed scenarios pinned by literal expectations.
module tb_cmult_sched;

  localparam int NR  = 4;
  localparam int LAT = 3;
  localparam int FD  = 4;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*32-1:0] mcand, mplier;
  logic [NR-1:0]   req_ready;
  logic [31:0]     m_mcand, m_mplier, m_result;
  logic            rsp_valid;
  logic [31:0]     rsp_data;
  logic [1:0]      rsp_id;
  logic            rsp_ready;
  logic            busy;

  cmult_sched #(.NUM_REQ(NR), .MULT_LAT(LAT), .FIFO_DEPTH(FD)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_mcand(mcand), .i_req_mplier(mplier),
    .o_req_ready(req_ready),
    .o_mult_mcand(m_mcand), .o_mult_mplier(m_mplier), .i_mult_result(m_result),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_id(rsp_id),
    .i_rsp_ready(rsp_ready), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
  endfunction

  // ---------------- FP16 complex arithmetic ----------------
  function automatic real pow2(input int e);
    real v = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) v = v * 2.0;
    else for (int i = 0; i < -e; i++) v = v / 2.0;
    return v;
  endfunction

  function automatic real fp2r(input logic [15:0] h);
    int  e = int'(h[14:10]);
    int  m = int'(h[9:0]);
    real v;
    if (e == 0) v = real'(m) * pow2(-24);
    else v = real'(1024 + m) * pow2(e - 25);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2fp(input real v);
    logic s = (v < 0.0);
    real  a = s ? -v : v;
    int   e = 15;
    int   m;
    if (a == 0.0) return {s, 15'h0};
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = int'((a - 1.0) * 1024.0);
    return {s, e[4:0], m[9:0]};
  endfunction

  function automatic logic [31:0] cmul(input logic [31:0] a, input logic [31:0] b);
    real ar = fp2r(a[31:16]), ai = fp2r(a[15:0]);
    real br = fp2r(b[31:16]), bi = fp2r(b[15:0]);
    return {r2fp(ar*br - ai*bi), r2fp(ar*bi + ai*br)};
  endfunction

  // Multiplier stand-in: LAT register stages, never reset, so stale results linger.
  logic [31:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= cmul(m_mcand, m_mplier);
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign m_result = mpipe[LAT-1];

  // ---------------- transaction model ----------------
  typedef struct {
    int          avail;
    logic [31:0] data;
    int          id;
  } exp_t;

  exp_t eq[$];
  int   rr  = 0;
  int   cyc = 0;
  int   xfer_ids[$];
  int   dut_pops[$];

  always @(negedge clk) begin : cmp
    bit          found, vis;
    int          gk, k;
    logic [3:0]  er;
    logic [31:0] emc, emp;
    exp_t        ne;
    if (rst) begin
      eq.delete();
      rr = 0;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end else begin
      found = 1'b0;
      gk    = 0;
      if (eq.size() < FD) begin
        for (int i = 0; i < NR; i++) begin
          k = (rr + i) % NR;
          if (!found && req_valid[k]) begin found = 1'b1; gk = k; end
        end
      end
      er  = found ? 4'(1 << gk) : 4'h0;
      emc = found ? mcand[32*gk +: 32] : 32'h0;
      emp = found ? mplier[32*gk +: 32] : 32'h0;
      vis = (eq.size() > 0) && (eq[0].avail <= cyc);
      chk("ready", 32'(req_ready), 32'(er));
      chk("mult_mcand", m_mcand, emc);
      chk("mult_mplier", m_mplier, emp);
      chk("rsp_valid", 32'(rsp_valid), 32'(vis));
      chk("busy", 32'(busy), 32'(eq.size() > 0));
      if (vis) begin
        chk("rsp_data", rsp_data, eq[0].data);
        chk("rsp_id", 32'(rsp_id), 32'(eq[0].id));
      end
      for (int i = 0; i < NR; i++) if (req_ready[i]) xfer_ids.push_back(i);
      if (rsp_valid && rsp_ready) dut_pops.push_back(int'(rsp_id));
      if (vis && rsp_ready) void'(eq.pop_front());
      if (found) begin
        ne.avail = cyc + LAT + 1;
        ne.data  = cmul(emc, emp);
        ne.id    = gk;
        eq.push_back(ne);
        rr = (gk + 1) % NR;
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input logic [31:0] mc, input logic [31:0] mp);
    mcand[32*k +: 32]  = mc;
    mplier[32*k +: 32] = mp;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 30) begin step(1); n++; end
    chk(name, 32'(busy), 32'h0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int x0, p0, n;
    rst = 1'b1; req_valid = '1; mcand = '0; mplier = '0; rsp_ready = 1'b1;
    #1;
    chk("init_ready", 32'(req_ready), 32'h0);
    chk("init_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("init_busy", 32'(busy), 32'h0);

    // Single op from requester 2: (1+2i)^2 = -3+4i, visible 4 cycles after transfer.
    step(2);
    rst = 1'b0; req_valid = 4'b0100;
    set_op(2, 32'h3C00_4000, 32'h3C00_4000);
    #1 chk("a_grant", 32'(req_ready), 32'h4);
    step(1); req_valid = '0;
    step(2); chk("a_not_early", 32'(rsp_valid), 32'h0);
    step(1);
    chk("a_valid", 32'(rsp_valid), 32'h1);
    chk("a_data", rsp_data, 32'hC200_4400);
    chk("a_id", 32'(rsp_id), 32'h2);
    wait_idle("a_idle");

    #1 rst = 1'b1;
    #5 rst = 1'b0;
    step(1);

    // Fairness: all valid, consumer always ready.
    for (int k = 0; k < NR; k++) set_op(k, {r2fp(real'(k + 1)), 16'h3C00}, 32'h4000_3800);
    x0 = xfer_ids.size(); p0 = dut_pops.size();
    req_valid = '1; n = 0;
    while (xfer_ids.size() - x0 < 8 && n < 60) begin step(1); n++; end
    req_valid = '0;
    chk("b_xfer_count", 32'(xfer_ids.size() - x0), 32'd8);
    wait_idle("b_idle");
    chk("b_pop_count", 32'(dut_pops.size() - p0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (x0 + i < xfer_ids.size()) chk("b_grant_order", 32'(xfer_ids[x0+i]), 32'(i % NR));
      if (p0 + i < dut_pops.size()) chk("b_rsp_order", 32'(dut_pops[p0+i]), 32'(i % NR));
    end

    // Backpressure: requester 0 streams into a stalled consumer.
    x0 = xfer_ids.size(); p0 = dut_pops.size();
    rsp_ready = 1'b0; req_valid = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      set_op(0, {r2fp(real'(i % 5 + 1)), 16'h4000}, 32'h3C00_3C00);
      step(1);
    end
    chk("c_xfers_stalled", 32'(xfer_ids.size() - x0), 32'd4);
    chk("c_ready_full", 32'(req_ready), 32'h0);
    chk("c_rsp_valid_full", 32'(rsp_valid), 32'h1);
    rsp_ready = 1'b1;
    #1;
    chk("c_no_same_cycle_credit", 32'(req_ready), 32'h0);
    chk("c_head_id", 32'(rsp_id), 32'h0);
    step(1);
    chk("c_resume", 32'(req_ready), 32'h1);
    for (int i = 0; i < 6; i++) begin
      set_op(0, {r2fp(real'(i + 2)), 16'hC000}, 32'h3800_3C00);
      step(1);
    end
    req_valid = '0;
    wait_idle("c_idle");
    chk("c_no_loss_dup", 32'(dut_pops.size() - p0), 32'(xfer_ids.size() - x0));

    // Reset mid-flight: one buffered, two in the multiplier.
    rsp_ready = 1'b0; req_valid = 4'b0001;
    step(1); req_valid = '0;
    step(1); req_valid = 4'b0001;
    step(2); req_valid = '0;
    chk("d_buffered", 32'(rsp_valid), 32'h1);
    chk("d_busy", 32'(busy), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("d_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("d_rst_busy", 32'(busy), 32'h0);
    #5 rst = 1'b0;
    p0 = dut_pops.size();
    step(1);
    req_valid = '1; rsp_ready = 1'b1;
    #1 chk("d_first_grant", 32'(req_ready), 32'h1);
    step(1); req_valid = '0;
    wait_idle("d_idle");
    chk("d_pops_after_rst", 32'(dut_pops.size() - p0), 32'd1);
    if (dut_pops.size() > p0) chk("d_pop_id", 32'(dut_pops[dut_pops.size()-1]), 32'h0);

    step(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
